if_bus_fetch: RTL and testbench

//  Instruction-fetch bus master between the PC stage and the IF/ID pipeline register.

---
 rtl/if_bus_fetch_pkg.sv | 20 ++
 rtl/if_bus_fetch_if.sv | 12 +
 rtl/if_bus_fetch.sv | 150 +++++++++++++++
 tb/tb_if_bus_fetch.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_bus_fetch_pkg.sv
// Shared types and constants for the instruction-fetch bus master.
package if_bus_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;
  localparam int STALL_W     = 6;
  localparam int STALL_IF    = 1;   // stall bit that holds the IF/ID register
  localparam int CNT_W       = 8;   // timeout counter width

  localparam logic [INST_W-1:0]      NOP_INST  = 32'h0000_0000;
  localparam logic [INST_ADDR_W-1:0] ZERO_ADDR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_bus_fetch_if.sv
// Instruction bus: req/ack read channel between the fetch master and memory.
interface if_bus_fetch_if;
  import if_bus_fetch_pkg::*;

  logic                   req;
  logic [INST_ADDR_W-1:0] addr;
  logic                   ack;
  logic [INST_W-1:0]      rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/if_bus_fetch.sv
// Instruction-fetch bus master: one bus read per PC value, stalls the pipeline
// while the read is outstanding, delivers word+address to IF/ID, and handles
// flushes and bus timeouts.
module if_bus_fetch
  import if_bus_fetch_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255   // 1..255
) (
  input  logic                   clk,
  input  logic                   rst,          // async, active low
  input  logic [INST_ADDR_W-1:0] pc,
  input  logic                   ce,
  input  logic [STALL_W-1:0]     stall,
  input  logic                   flush,
  if_bus_fetch_if.master         ibus,
  output logic [INST_W-1:0]      inst_o,
  output logic [INST_ADDR_W-1:0] inst_addr_o,
  output logic                   inst_valid,
  output logic                   stallreq_if,
  output logic                   ibus_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  fetch_state_e           r_state, w_state_nxt;
  logic                   r_req, w_req_nxt;
  logic [INST_ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [INST_W-1:0]      r_inst, w_inst_nxt;
  logic [INST_ADDR_W-1:0] r_iaddr, w_iaddr_nxt;
  logic                   r_valid, w_valid_nxt;
  logic                   r_err, w_err_nxt;
  logic                   w_stallreq;
  logic                   w_cnt_last;
  logic                   w_drop;
  logic                   w_unused_stall;

  assign w_cnt_last     = (r_cnt == CNT_LAST);
  // Losing ce mid-read means the PC stage no longer wants this word.
  assign w_drop         = flush | ~ce;
  assign w_unused_stall = ^{stall[STALL_W-1:STALL_IF+1], stall[STALL_IF-1:0]};

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_addr  <= ZERO_ADDR;
      r_cnt   <= '0;
      r_inst  <= NOP_INST;
      r_iaddr <= ZERO_ADDR;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_addr  <= w_addr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_inst  <= w_inst_nxt;
      r_iaddr <= w_iaddr_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state and next-output decode; everything holds unless a case moves it.
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_inst_nxt  = r_inst;
    w_iaddr_nxt = r_iaddr;
    w_valid_nxt = r_valid;
    w_err_nxt   = 1'b0;
    w_stallreq  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // Stall the PC until its fetch has actually issued.
        w_stallreq = ce & ~flush;
        if (ce && !flush) begin
          w_addr_nxt  = pc;
          w_req_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        w_stallreq = 1'b1;
        if (ibus.ack) begin
          // Ack wins over timeout in the same cycle.
          w_req_nxt = 1'b0;
          if (w_drop) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_inst_nxt  = ibus.rdata;
            w_iaddr_nxt = r_addr;
            w_valid_nxt = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end else if (w_cnt_last) begin
          w_req_nxt = 1'b0;
          w_err_nxt = 1'b1;
          if (w_drop) begin
            w_state_nxt = ST_IDLE;
          end else begin
            // Timed-out fetch delivers a NOP so the pipeline keeps moving.
            w_inst_nxt  = NOP_INST;
            w_iaddr_nxt = r_addr;
            w_valid_nxt = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          // Request stays up: the bus must see the ack before req drops.
          if (w_drop) w_state_nxt = ST_DISCARD;
        end
      end
      ST_HOLD: begin
        if (flush || !stall[STALL_IF]) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        w_stallreq = 1'b1;
        if (ibus.ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
        end else if (w_cnt_last) begin
          w_req_nxt   = 1'b0;
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign ibus.req    = r_req;
  assign ibus.addr   = r_addr;
  assign inst_o      = r_inst;
  assign inst_addr_o = r_iaddr;
  assign inst_valid  = r_valid;
  assign ibus_err    = r_err;
  assign stallreq_if = w_stallreq;

endmodule

// File: tb/tb_if_bus_fetch.sv
// Directed bench for if_bus_fetch (TIMEOUT_CYC=8).
module tb_if_bus_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        ce;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] inst_o, inst_addr_o;
  logic        inst_valid, stallreq_if, ibus_err;

  int checks   = 0;
  int failures = 0;

  if_bus_fetch_if ibus();

  if_bus_fetch #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .pc(pc), .ce(ce), .stall(stall), .flush(flush),
    .ibus(ibus), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .inst_valid(inst_valid), .stallreq_if(stallreq_if), .ibus_err(ibus_err)
  );

  always #5 clk = ~clk;

  // Advance one clock; sample/drive 1ns after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if ({ibus.req, ibus.addr, inst_o, inst_addr_o, inst_valid, ibus_err} !== 99'd0) begin
      failures++;
      $display("FAIL reset_outputs req=%b addr=%h inst=%h iaddr=%h v=%b err=%b, all want 0",
               ibus.req, ibus.addr, inst_o, inst_addr_o, inst_valid, ibus_err);
    end
    rst = 1'b1;
  endtask

  task automatic test_basic_fetch();
    ce = 1'b1; pc = 32'hbfb0_0000;
    #1;
    checks++;
    if (stallreq_if !== 1'b1) begin
      failures++; $display("FAIL idle_stallreq got=%b want=1", stallreq_if);
    end
    step();
    checks++;
    if (ibus.req !== 1'b1 || ibus.addr !== 32'hbfb0_0000 || stallreq_if !== 1'b1) begin
      failures++;
      $display("FAIL basic_req req=%b addr=%h sr=%b want 1/bfb00000/1", ibus.req, ibus.addr, stallreq_if);
    end
    ibus.ack = 1'b1; ibus.rdata = 32'h2408_0001;
    step();
    ibus.ack = 1'b0; ce = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst_o !== 32'h2408_0001 || inst_addr_o !== 32'hbfb0_0000 ||
        stallreq_if !== 1'b0 || ibus.req !== 1'b0) begin
      failures++;
      $display("FAIL basic_hold v=%b inst=%h iaddr=%h sr=%b req=%b want 1/24080001/bfb00000/0/0",
               inst_valid, inst_o, inst_addr_o, stallreq_if, ibus.req);
    end
    step();
    checks++;
    if (inst_valid !== 1'b0 || ibus.req !== 1'b0 || stallreq_if !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle v=%b req=%b sr=%b want 0/0/0", inst_valid, ibus.req, stallreq_if);
    end
  endtask

  task automatic test_ack_delay();
    int bad = 0;
    ce = 1'b1; pc = 32'h0000_1000;
    step();
    for (int i = 0; i < 6; i++) begin
      if (ibus.req !== 1'b1 || ibus.addr !== 32'h0000_1000 || stallreq_if !== 1'b1 || inst_valid !== 1'b0)
        bad++;
      if (i < 5) step();
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL delay_stable bad_cycles=%0d want 0", bad);
    end
    ibus.ack = 1'b1; ibus.rdata = 32'h8c01_0004;
    step();
    ibus.ack = 1'b0; ce = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst_o !== 32'h8c01_0004 || inst_addr_o !== 32'h0000_1000) begin
      failures++;
      $display("FAIL delay_data v=%b inst=%h iaddr=%h want 1/8c010004/00001000", inst_valid, inst_o, inst_addr_o);
    end
    step();
  endtask

  task automatic test_hold_stall();
    int bad = 0;
    ce = 1'b1; pc = 32'h0000_1004;
    step();
    ibus.ack = 1'b1; ibus.rdata = 32'h1234_5678;
    stall = 6'b000010;
    step();
    ibus.ack = 1'b0; ce = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (inst_valid !== 1'b1 || inst_o !== 32'h1234_5678 || inst_addr_o !== 32'h0000_1004 ||
          stallreq_if !== 1'b0 || ibus.req !== 1'b0)
        bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL hold_stable bad_cycles=%0d want 0", bad);
    end
    stall = 6'b000000;
    step();
    checks++;
    if (inst_valid !== 1'b0 || ibus.req !== 1'b0) begin
      failures++; $display("FAIL hold_release v=%b req=%b want 0/0", inst_valid, ibus.req);
    end
  endtask

  task automatic test_flush_req();
    int bad = 0;
    ce = 1'b1; pc = 32'h0000_2000;
    step();
    step();
    flush = 1'b1;
    #1;
    checks++;
    if (stallreq_if !== 1'b1) begin
      failures++; $display("FAIL flush_req_stallreq got=%b want 1", stallreq_if);
    end
    step();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (ibus.req !== 1'b1 || ibus.addr !== 32'h0000_2000 || stallreq_if !== 1'b1 || inst_valid !== 1'b0)
        bad++;
      if (i < 2) step();
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL discard_hold bad_cycles=%0d want 0", bad);
    end
    ibus.ack = 1'b1; ibus.rdata = 32'hdead_beef;
    pc = 32'h0000_3000;
    step();
    ibus.ack = 1'b0;
    checks++;
    if (ibus.req !== 1'b0 || inst_valid !== 1'b0 || inst_o === 32'hdead_beef || stallreq_if !== 1'b1) begin
      failures++;
      $display("FAIL discard_drop req=%b v=%b inst=%h sr=%b want 0/0/!deadbeef/1",
               ibus.req, inst_valid, inst_o, stallreq_if);
    end
    step();
    checks++;
    if (ibus.req !== 1'b1 || ibus.addr !== 32'h0000_3000) begin
      failures++; $display("FAIL refetch req=%b addr=%h want 1/00003000", ibus.req, ibus.addr);
    end
    ibus.ack = 1'b1; ibus.rdata = 32'h0000_0021;
    step();
    ibus.ack = 1'b0; ce = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst_o !== 32'h0000_0021 || inst_addr_o !== 32'h0000_3000) begin
      failures++;
      $display("FAIL refetch_data v=%b inst=%h iaddr=%h want 1/00000021/00003000", inst_valid, inst_o, inst_addr_o);
    end
    step();
  endtask

  task automatic test_flush_hold();
    ce = 1'b1; pc = 32'h0000_3004;
    step();
    ibus.ack = 1'b1; ibus.rdata = 32'h0000_0042;
    stall = 6'b000010;
    step();
    ibus.ack = 1'b0; ce = 1'b0; flush = 1'b1;
    step();
    checks++;
    if (inst_valid !== 1'b0) begin
      failures++; $display("FAIL flush_hold v=%b want 0", inst_valid);
    end
    ce = 1'b1;
    #1;
    checks++;
    if (stallreq_if !== 1'b0) begin
      failures++; $display("FAIL flush_idle_stallreq got=%b want 0", stallreq_if);
    end
    step();
    checks++;
    if (ibus.req !== 1'b0) begin
      failures++; $display("FAIL flush_idle_noreq req=%b want 0", ibus.req);
    end
    flush = 1'b0; ce = 1'b0; stall = 6'b000000;
    step();
  endtask

  task automatic test_timeout();
    int bad = 0;
    ce = 1'b1; pc = 32'h0000_4000;
    step();
    for (int i = 0; i < 8; i++) begin
      if (ibus.req !== 1'b1 || ibus_err !== 1'b0 || inst_valid !== 1'b0) bad++;
      if (i < 7) step();
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL timeout_wait bad_cycles=%0d want 0", bad);
    end
    step();
    ce = 1'b0;
    checks++;
    if (ibus_err !== 1'b1 || ibus.req !== 1'b0 || inst_valid !== 1'b1 ||
        inst_o !== 32'h0 || inst_addr_o !== 32'h0000_4000) begin
      failures++;
      $display("FAIL timeout_abort err=%b req=%b v=%b inst=%h iaddr=%h want 1/0/1/00000000/00004000",
               ibus_err, ibus.req, inst_valid, inst_o, inst_addr_o);
    end
    step();
    checks++;
    if (ibus_err !== 1'b0 || inst_valid !== 1'b0) begin
      failures++; $display("FAIL timeout_pulse err=%b v=%b want 0/0", ibus_err, inst_valid);
    end
  endtask

  task automatic test_ack_at_timeout();
    ce = 1'b1; pc = 32'h0000_4100;
    repeat (8) step();
    ibus.ack = 1'b1; ibus.rdata = 32'h0bad_cafe;
    step();
    ibus.ack = 1'b0; ce = 1'b0;
    checks++;
    if (ibus_err !== 1'b0 || inst_valid !== 1'b1 || inst_o !== 32'h0bad_cafe) begin
      failures++;
      $display("FAIL ack_beats_timeout err=%b v=%b inst=%h want 0/1/0badcafe", ibus_err, inst_valid, inst_o);
    end
    step();
  endtask

  task automatic test_back_to_back();
    ce = 1'b1; pc = 32'h0000_5000;
    step();
    ibus.ack = 1'b1; ibus.rdata = 32'h1111_1111;
    step();
    ibus.ack = 1'b0; pc = 32'h0000_5004;
    step();
    checks++;
    if (inst_valid !== 1'b0 || ibus.req !== 1'b0 || stallreq_if !== 1'b1) begin
      failures++;
      $display("FAIL b2b_idle v=%b req=%b sr=%b want 0/0/1", inst_valid, ibus.req, stallreq_if);
    end
    step();
    ibus.ack = 1'b1; ibus.rdata = 32'h2222_2222;
    checks++;
    if (ibus.req !== 1'b1 || ibus.addr !== 32'h0000_5004) begin
      failures++; $display("FAIL b2b_req req=%b addr=%h want 1/00005004", ibus.req, ibus.addr);
    end
    step();
    ibus.ack = 1'b0; ce = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst_o !== 32'h2222_2222 || inst_addr_o !== 32'h0000_5004) begin
      failures++;
      $display("FAIL b2b_data v=%b inst=%h iaddr=%h want 1/22222222/00005004", inst_valid, inst_o, inst_addr_o);
    end
    step();
  endtask

  task automatic test_reset_mid_req();
    ce = 1'b1; pc = 32'h0000_6000;
    step();
    #2;
    ce = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if ({ibus.req, ibus.addr, inst_o, inst_addr_o, inst_valid, ibus_err, stallreq_if} !== 100'd0) begin
      failures++;
      $display("FAIL async_reset req=%b addr=%h inst=%h iaddr=%h v=%b err=%b sr=%b, all want 0",
               ibus.req, ibus.addr, inst_o, inst_addr_o, inst_valid, ibus_err, stallreq_if);
    end
    step();
    rst = 1'b1;
    ibus.ack = 1'b1; ibus.rdata = 32'h5555_5555;
    step();
    ibus.ack = 1'b0;
    checks++;
    if (ibus.req !== 1'b0 || inst_valid !== 1'b0) begin
      failures++; $display("FAIL stale_ack req=%b v=%b want 0/0", ibus.req, inst_valid);
    end
    ce = 1'b1; pc = 32'h0000_7000;
    step();
    step();
    checks++;
    if (ibus.req !== 1'b1 || ibus.addr !== 32'h0000_7000 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_fetch req=%b addr=%h v=%b want 1/00007000/0", ibus.req, ibus.addr, inst_valid);
    end
    ibus.ack = 1'b1; ibus.rdata = 32'h7777_0000;
    step();
    ibus.ack = 1'b0; ce = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst_o !== 32'h7777_0000 || inst_addr_o !== 32'h0000_7000) begin
      failures++;
      $display("FAIL post_reset_data v=%b inst=%h iaddr=%h want 1/77770000/00007000", inst_valid, inst_o, inst_addr_o);
    end
    step();
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; pc = '0; stall = '0; flush = 1'b0;
    ibus.ack = 1'b0; ibus.rdata = '0;
    #2 rst = 1'b0;
    test_reset();
    test_basic_fetch();
    test_ack_delay();
    test_hold_stall();
    test_flush_req();
    test_flush_hold();
    test_timeout();
    test_ack_at_timeout();
    test_back_to_back();
    test_reset_mid_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
